// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with stall, branch, call/return RAS and halt.
// Optional PC_ALIGN_CHECK_EN forces loaded targets word-aligned and flags the correction.
module pc_sequencer #(
    parameter int WIDTH      = 32,
    parameter int RESET_ADDR = 0,
    parameter int STEP       = 4,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       halt,
    input  logic                       branch_taken,
    input  logic [WIDTH-1:0]           branch_target,
    input  logic                       call,
    input  logic [WIDTH-1:0]           call_target,
    input  logic                       ret,
    output logic [WIDTH-1:0]           pc,
    output logic                       valid,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_full,
    output logic                       ras_empty,
    output logic                       ret_underflow,
    output logic                       misaligned
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q, pc_inc, tgt, tgt_fix;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_up, top_dn;
    logic [CW-1:0]    cnt_q;
    logic             valid_q, unf_q, mis_q, mis_d;
    logic             go, do_br, do_call, do_ret, do_pop, load;

    assign go      = state_q == RUN && !stall && !halt;
    assign do_br   = go && branch_taken;
    assign do_call = go && !branch_taken && call;
    assign do_ret  = go && !branch_taken && !call && ret;
    assign do_pop  = do_ret && !ras_empty;
    assign load    = do_br || do_call || do_pop;
    assign pc_inc  = pc_q + WIDTH'(STEP);
    assign tgt     = do_br ? branch_target : do_call ? call_target : ras_q[top_q];
    assign top_up  = top_q == PW'(RAS_DEPTH - 1) ? '0 : top_q + 1'b1;
    assign top_dn  = top_q == '0 ? PW'(RAS_DEPTH - 1) : top_q - 1'b1;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt_fix = {tgt[WIDTH-1:2], 2'b00};
    assign mis_d   = load && tgt[1:0] != 2'b00;
`else
    assign tgt_fix = tgt;
    assign mis_d   = 1'b0;
`endif

    assign pc            = pc_q;
    assign valid         = valid_q;
    assign ras_count     = cnt_q;
    assign ras_full      = cnt_q == CW'(RAS_DEPTH);
    assign ras_empty     = cnt_q == '0;
    assign ret_underflow = unf_q;
    assign misaligned    = mis_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= WIDTH'(RESET_ADDR);
            valid_q <= 1'b0;
            top_q   <= PW'(RAS_DEPTH - 1);
            cnt_q   <= '0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            mis_q <= mis_d;
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: if (!stall) begin
                    if (halt) begin
                        state_q <= HALT;
                        valid_q <= 1'b0;
                    end else begin
                        pc_q <= load ? tgt_fix : pc_inc;
                        // a full stack overwrites its oldest slot, so the count saturates
                        if (do_call) begin
                            top_q <= top_up;
                            cnt_q <= ras_full ? cnt_q : cnt_q + 1'b1;
                        end
                        if (do_pop) begin
                            top_q <= top_dn;
                            cnt_q <= cnt_q - 1'b1;
                        end
                        if (do_ret && ras_empty) unf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK)
        if (do_call) ras_q[top_up] <= pc_inc;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, stall, halt, branch_taken, call, ret;
    logic [31:0] branch_target, call_target, pc;
    logic        valid, ras_full, ras_empty, ret_underflow, misaligned;
    logic [2:0]  ras_count;
    int          n_vec = 0;
    int          n_err = 0;

    pc_sequencer dut (
        .CLK(clk), .reset(reset), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .call(call), .call_target(call_target), .ret(ret),
        .pc(pc), .valid(valid), .ras_count(ras_count), .ras_full(ras_full),
        .ras_empty(ras_empty), .ret_underflow(ret_underflow), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 0; halt = 0; branch_taken = 0; call = 0; ret = 0;
        branch_target = '0; call_target = '0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_empty", 32'(ras_empty), 1);
        step();
        step();
        check("rst2_pc", pc, 0);
        check("rst2_valid", 32'(valid), 0);
        reset = 1'b0;
        step();
        check("boot_pc", pc, 0);
        check("boot_valid", 32'(valid), 1);
        step();
        check("inc_4", pc, 32'h4);
        step();
        check("inc_8", pc, 32'h8);
        stall = 1; branch_taken = 1; branch_target = 32'h100;
        step();
        check("stall_pc", pc, 32'h8);
        stall = 0;
        step();
        check("branch_pc", pc, 32'h100);
        branch_target = 32'h10;
        step();
        check("br_10", pc, 32'h10);
        branch_taken = 0; call = 1; call_target = 32'h200;
        step();
        check("call_pc", pc, 32'h200);
        check("call_cnt", 32'(ras_count), 1);
        call = 0;
        step();
        step();
        check("inc_208", pc, 32'h208);
        ret = 1;
        step();
        check("ret_pc", pc, 32'h14);
        check("ret_cnt", 32'(ras_count), 0);
        check("ret_empty", 32'(ras_empty), 1);
        ret = 0; branch_taken = 1; branch_target = 32'h40; call = 1; call_target = 32'h900;
        step();
        check("prio_br_pc", pc, 32'h40);
        check("prio_no_push", 32'(ras_count), 0);
        branch_taken = 0;
        for (int i = 0; i < 5; i++) begin
            call_target = 32'(i + 1) * 32'h1000;
            step();
            check("nest_pc", pc, call_target);
            check("nest_cnt", 32'(ras_count), (i < 3) ? 32'(i + 1) : 32'd4);
        end
        check("nest_full", 32'(ras_full), 1);
        call = 0; ret = 1;
        step();
        check("pop1_pc", pc, 32'h4004);
        check("pop1_cnt", 32'(ras_count), 3);
        step();
        check("pop2_pc", pc, 32'h3004);
        step();
        check("pop3_pc", pc, 32'h2004);
        step();
        check("pop4_pc", pc, 32'h1004);
        check("pop4_empty", 32'(ras_empty), 1);
        check("pop4_unf", 32'(ret_underflow), 0);
        step();
        check("unf_pc", pc, 32'h1008);
        check("unf_flag", 32'(ret_underflow), 1);
        ret = 0;
        step();
        check("unf_sticky_pc", pc, 32'h100C);
        check("unf_sticky", 32'(ret_underflow), 1);
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        step();
        check("wrap_br", pc, 32'hFFFF_FFFC);
        branch_taken = 0;
        step();
        check("wrap_pc", pc, 32'h0);
        branch_taken = 1; branch_target = 32'h103;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", pc, 32'h100);
        check("align_mis", 32'(misaligned), 1);
`else
        check("align_pc", pc, 32'h103);
        check("align_mis", 32'(misaligned), 0);
`endif
        branch_taken = 0;
        step();
        check("align_mis_clr", 32'(misaligned), 0);
        branch_taken = 1; branch_target = 32'h30;
        step();
        check("pre_halt_pc", pc, 32'h30);
        branch_taken = 0; halt = 1;
        step();
        check("halt_pc", pc, 32'h30);
        check("halt_valid", 32'(valid), 0);
        halt = 0; branch_taken = 1; branch_target = 32'h500; call = 1; call_target = 32'h600;
        step();
        step();
        check("halt_frozen_pc", pc, 32'h30);
        check("halt_frozen_valid", 32'(valid), 0);
        check("halt_no_push", 32'(ras_count), 0);
        branch_taken = 0; call = 0;
        reset = 1;
        step();
        reset = 0;
        step();
        check("reboot_pc", pc, 0);
        check("reboot_valid", 32'(valid), 1);
        check("reboot_unf", 32'(ret_underflow), 0);
        call = 1; call_target = 32'h80;
        step();
        call_target = 32'h90;
        step();
        check("two_cnt", 32'(ras_count), 2);
        call = 0;
        #2;
        reset = 1;
        #1;
        check("async_pc", pc, 0);
        check("async_cnt", 32'(ras_count), 0);
        check("async_valid", 32'(valid), 0);
        step();
        reset = 0;
        step();
        ret = 1;
        step();
        check("post_rst_ret_pc", pc, 32'h4);
        check("post_rst_unf", 32'(ret_underflow), 1);
        ret = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the lab processor datapath; produces the 32-bit fetch address each cycle.
- Its `pc` output feeds the downstream 32-bit pipeline register.
- Supports sequential increment, stall, taken branch, call/return via a small return-address stack (RAS), and a halt state.

Parameters:
- WIDTH, 32: address width.
- RESET_ADDR, 0: value of `pc` in reset and BOOT.
- STEP, 4: increment added for sequential flow.
- RAS_DEPTH, 4: number of return-address stack entries (≥2).

Ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold `pc` and RAS this cycle.
- halt  in  1  request transition to HALT.
- branch_taken  in  1  load `branch_target`.
- branch_target  in  WIDTH  branch destination.
- call  in  1  push return address, load `call_target`.
- call_target  in  WIDTH  call destination.
- ret  in  1  pop RAS into `pc`.
- pc  out  WIDTH  current fetch address (registered).
- valid  out  1  `pc` is a live fetch address (registered).
- ras_count  out  clog2(RAS_DEPTH)+1  occupied RAS entries.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.
- ret_underflow  out  1  sticky: ret seen with empty RAS.
- misaligned  out  1  see Optional Feature.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - pc = RESET_ADDR; valid = 0; ras_count = 0; ret_underflow = 0; misaligned = 0; state = BOOT.
  - RAS contents are don't-care.
  - Reset asserted mid-operation discards all stack contents and any pending action.
- FSM states BOOT, RUN, HALT, all transitions on rising CLK:
  - BOOT → RUN at the first edge with reset low. pc holds RESET_ADDR; valid becomes 1. All control inputs are ignored in BOOT.
  - RUN → HALT when halt = 1 and stall = 0. On that edge valid becomes 0 and pc holds.
  - HALT is exited only by reset. All inputs are ignored.
- RUN actions, one per cycle, fixed priority: stall > halt > branch_taken > call > ret > increment.
  - stall: pc, RAS and flags unchanged.
  - branch_taken: pc ← branch_target.
  - call: push (pc + STEP) mod 2^WIDTH; pc ← call_target.
    - If RAS is full, the oldest entry is dropped (circular overwrite), ras_count stays RAS_DEPTH and the new entry is the top.
  - ret with RAS non-empty: pc ← top entry; pop.
  - ret with RAS empty: pc ← pc + STEP; ret_underflow ← 1 (sticky until reset).
  - Otherwise: pc ← pc + STEP. Wraps modulo 2^WIDTH, no flag.
- Simultaneous requests: only the highest-priority action takes effect. Lower-priority requests are dropped, with no push or pop and no flag side effects.
- Latency: every action is visible on `pc` one cycle after the sampling edge.
- `ras_full` and `ras_empty` are combinational from ras_count.
- RAS implementation: circular buffer with top pointer.
  - Push increments the pointer modulo RAS_DEPTH.
  - Pop decrements it modulo RAS_DEPTH.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Any loaded target (branch_target, call_target, popped RAS value) with bits [1:0] ≠ 0 is loaded with bits [1:0] forced to 0.
  - misaligned pulses high for exactly the cycle in which that corrected pc is presented.
- Undefined:
  - Targets are loaded unmodified.
  - misaligned is tied to 0.

Test Plan:
- Reset/boot: reset=1 for 2 cycles, then release.
  - While reset is high: pc=0, valid=0.
  - First edge after release: pc=0, valid=1.
  - Following edges: pc=4, 8, 12.
- Stall/priority: at pc=8 assert stall+branch_taken (target 0x100) for 1 cycle → pc stays 8. Next cycle branch_taken only → pc=0x100.
- Call/return: at pc=0x10, call to 0x200 → pc=0x200, ras_count=1. Two increments → 0x208. ret → pc=0x14, ras_count=0, ras_empty=1.
- RAS overflow/underflow (RAS_DEPTH=4):
  - Five nested calls from pc values A..E → ras_full=1, ras_count=4.
  - Five rets → pc returns to E+4, D+4, C+4, B+4.
  - The fifth ret gives pc+4 and ret_underflow=1, which stays 1 afterwards.
- Halt and mid-operation reset:
  - halt at pc=0x30 → valid=0, pc frozen at 0x30 regardless of branch/call inputs.
  - Assert reset with 2 RAS entries → pc=0, ras_count=0 immediately, before the next clock edge.
- Wrap and alignment: branch to 0xFFFFFFFC, then increment → pc=0x00000000.
  - With PC_ALIGN_CHECK_EN: branch to 0x103 → pc=0x100, misaligned=1 for one cycle.
